// File: rtl/pmem_line_responder.sv
// Fixed-latency main-memory model for the cache line protocol: 128-bit line
// reads/writes against an internal store, with a sticky protocol-violation flag.
module pmem_line_responder #(
  parameter int unsigned LINES_LOG2 = 12,
  parameter int unsigned LATENCY    = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         busy,
  output logic         protocol_error
);
  localparam int unsigned LINE_W    = 128;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned NUM_LINES = 1 << LINES_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      counter, counter_next;
  logic [LINES_LOG2-1:0] idx, idx_next, addr_idx;
  logic                  op_write, op_write_next;
  logic [LINE_W-1:0]     wdata_q, wdata_next;
  logic                  error_set;
  logic                  unused_addr;
  logic [LINE_W-1:0]     mem [NUM_LINES];

  // Offset bits and index bits above the store size alias away.
  assign addr_idx    = pmem_address[LINES_LOG2+3:4];
  assign unused_addr = ^pmem_address;

  // Next-state and access bookkeeping.
  always_comb begin
    state_next    = state;
    counter_next  = counter;
    idx_next      = idx;
    op_write_next = op_write;
    wdata_next    = wdata_q;
    error_set     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          idx_next      = addr_idx;
          op_write_next = pmem_write;
          wdata_next    = pmem_wdata;
          error_set     = pmem_read && pmem_write;
          counter_next  = CNT_W'(LATENCY - 1);
          state_next    = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // Initiator dropping its request mid-access aborts it without commit.
        if (op_write ? !pmem_write : !pmem_read) begin
          error_set    = 1'b1;
          counter_next = '0;
          state_next   = IDLE;
        end else begin
          counter_next = counter - CNT_W'(1);
          if (counter == CNT_W'(1)) state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; read data is captured on the RESP entry edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      counter        <= '0;
      idx            <= '0;
      op_write       <= 1'b0;
      wdata_q        <= '0;
      pmem_resp      <= 1'b0;
      busy           <= 1'b0;
      pmem_rdata     <= '0;
      protocol_error <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      idx       <= idx_next;
      op_write  <= op_write_next;
      wdata_q   <= wdata_next;
      pmem_resp <= (state_next == RESP);
      busy      <= (state_next != IDLE);
      if (error_set) protocol_error <= 1'b1;
      if (state_next == RESP && !op_write_next) pmem_rdata <= mem[idx_next];
    end
  end

  // Line store is not reset; a write commits on the edge that ends RESP.
  always_ff @(posedge clk) begin
    if (reset_n && state == RESP && op_write) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench: transaction-level model predicts every output each cycle
// for two instances (LATENCY=4/12 index bits and LATENCY=1/8 index bits).
module tb_pmem_line_responder;
  logic         clk = 1'b0;
  logic [1:0]   rst_n, rd, wr, resp, busy, perr;
  logic [15:0]  addr  [2];
  logic [127:0] wd    [2];
  logic [127:0] rdata [2];

  logic [1:0]   e_resp, e_busy, e_err;
  logic [127:0] e_rdata [2];
  logic [127:0] mm0 [4096];
  logic [127:0] mm1 [256];
  bit           chk_on = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  pmem_line_responder #(.LINES_LOG2(12), .LATENCY(4)) dut0 (
    .clk(clk), .reset_n(rst_n[0]), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wd[0]), .pmem_resp(resp[0]),
    .pmem_rdata(rdata[0]), .busy(busy[0]), .protocol_error(perr[0]));

  pmem_line_responder #(.LINES_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(rst_n[1]), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wd[1]), .pmem_resp(resp[1]),
    .pmem_rdata(rdata[1]), .busy(busy[1]), .protocol_error(perr[1]));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("resp%0d", d), 128'(resp[d]), 128'(e_resp[d]));
        chk($sformatf("busy%0d", d), 128'(busy[d]), 128'(e_busy[d]));
        chk($sformatf("perr%0d", d), 128'(perr[d]), 128'(e_err[d]));
        chk($sformatf("rdata%0d", d), rdata[d], e_rdata[d]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic int lat(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [127:0] mget(input int d, input logic [15:0] a);
    if (d == 0) return mm0[a[15:4]];
    return mm1[a[11:4]];
  endfunction

  task automatic mset(input int d, input logic [15:0] a, input logic [127:0] v);
    if (d == 0) mm0[a[15:4]] = v;
    else        mm1[a[11:4]] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rst_pulse(input int d);
    rst_n[d] = 1'b0;
    tick();
    e_resp[d] = 1'b0; e_busy[d] = 1'b0; e_err[d] = 1'b0; e_rdata[d] = '0;
    rst_n[d] = 1'b1;
  endtask

  // One access: request accepted on the next edge, resp LATENCY cycles later.
  // drop_at / rst_at > 0 abort the access in that cycle after acceptance.
  task automatic access(input int d, input bit do_rd, input bit do_wr,
                        input logic [15:0] a, input logic [127:0] data,
                        input int drop_at, input int rst_at);
    int l;
    l = lat(d);
    rd[d] = do_rd; wr[d] = do_wr; addr[d] = a; wd[d] = data;
    for (int k = 1; k <= l; k++) begin
      tick();
      if (k == 1 && do_rd && do_wr) e_err[d] = 1'b1;
      e_busy[d] = 1'b1;
      e_resp[d] = (k == l);
      if (k == l && !do_wr) e_rdata[d] = mget(d, a);
      if (k == drop_at) begin
        rd[d] = 1'b0; wr[d] = 1'b0;
        tick();
        e_busy[d] = 1'b0; e_resp[d] = 1'b0; e_err[d] = 1'b1;
        return;
      end
      if (k == rst_at) begin
        rst_n[d] = 1'b0;
        tick();
        e_resp[d] = 1'b0; e_busy[d] = 1'b0; e_err[d] = 1'b0; e_rdata[d] = '0;
        rst_n[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
        return;
      end
    end
    tick();
    if (do_wr) mset(d, a, data);
    e_resp[d] = 1'b0; e_busy[d] = 1'b0;
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] d0, d2, d3, la, lb, lc, le, lw;
    rst_n = 2'b00; rd = 2'b00; wr = 2'b00;
    e_resp = 2'b00; e_busy = 2'b00; e_err = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wd[d] = '0; e_rdata[d] = '0;
    end
    tick(); tick();
    chk_on = 1'b1;
    chk("reset_resp", 128'(resp), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_perr", 128'(perr), 128'(0));
    chk("reset_rdata", rdata[0], 128'(0));
    rst_n = 2'b11;
    tick();

    d0 = rnd128(); d2 = rnd128(); d3 = rnd128();
    la = rnd128(); lb = rnd128(); lc = rnd128(); le = rnd128();
    access(0, 0, 1, 16'h0080, d0, 0, 0); idle(1);
    access(0, 0, 1, 16'h0200, d2, 0, 0); idle(1);
    access(0, 0, 1, 16'h0300, d3, 0, 0); idle(2);

    lw = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    access(0, 0, 1, 16'h1230, lw, 0, 0);
    chk("wr1230_perr", 128'(perr[0]), 128'(0));
    chk("model_1230", mm0[12'h123], 128'h00112233_44556677_8899AABB_CCDDEEFF);
    idle(1);
    access(0, 1, 0, 16'h1238, '0, 0, 0);
    chk("rd1238", rdata[0], 128'h00112233_44556677_8899AABB_CCDDEEFF);

    access(0, 0, 1, 16'h0040, la, 0, 0);
    access(0, 1, 0, 16'h0080, '0, 0, 0);
    chk("b2b_rd0080", rdata[0], d0);
    access(0, 1, 0, 16'h0040, '0, 0, 0);
    chk("rd0040", rdata[0], la);

    access(0, 1, 1, 16'h0100, lb, 0, 0);
    chk("both_perr", 128'(perr[0]), 128'(1));
    idle(2);
    access(0, 1, 0, 16'h0100, '0, 0, 0);
    chk("rd0100", rdata[0], lb);
    chk("perr_sticky", 128'(perr[0]), 128'(1));

    rst_pulse(0);
    chk("perr_cleared", 128'(perr[0]), 128'(0));
    access(0, 0, 1, 16'h0200, lc, 2, 0);
    chk("drop_perr", 128'(perr[0]), 128'(1));
    idle(1);
    access(0, 1, 0, 16'h0200, '0, 0, 0);
    chk("rd0200_old", rdata[0], d2);

    access(0, 0, 1, 16'h0300, rnd128(), 0, 3);
    chk("rst_abort_resp", 128'(resp[0]), 128'(0));
    chk("rst_abort_rdata", rdata[0], 128'(0));
    idle(1);
    access(0, 1, 0, 16'h0300, '0, 0, 0);
    chk("rd0300_kept", rdata[0], d3);

    access(1, 0, 1, 16'h0050, le, 0, 0);
    access(1, 1, 0, 16'h0050, '0, 0, 0);
    chk("l1_rd0050", rdata[1], le);
    idle(1);
    access(1, 1, 0, 16'hF058, '0, 0, 0);
    chk("l1_alias", rdata[1], le);

    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) begin
        logic [15:0] a;
        a = (d == 0) ? 16'(16'h4000 + k * 16) : 16'(16'h0100 + k * 16);
        access(d, 0, 1, a, rnd128(), 0, 0);
      end

    for (int n = 0; n < 120; n++) begin
      int d, op, drop;
      logic [15:0] a;
      d  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 9));
      a  = 16'($urandom);
      if (d == 0) a[15:4] = 12'(12'h400 + $urandom_range(0, 7));
      else        a[11:4] = 8'(8'h10 + $urandom_range(0, 7));
      drop = (d == 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (op < 5)       access(d, 1, 0, a, '0, drop, 0);
      else if (op < 9)  access(d, 0, 1, a, rnd128(), drop, 0);
      else              access(d, 1, 1, a, rnd128(), drop, 0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Physical-memory responder on the cache-to-main-memory interface: the target side of the pmem_read/pmem_write line protocol that the cache datapath/controller initiates.
- Serves 128-bit line reads and line writes against an internal line store, with a configurable fixed access latency.
- Returns a one-cycle pmem_resp for every request.
- Used as the main-memory model in cache-level simulation and as the synthesizable stand-in memory for the top-level build.

Parameters:
- LINES_LOG2, 12, log2 of number of 16-byte lines stored (4096 lines = full 64 KB LC-3b space).
- LATENCY, 4, cycles from request acceptance to pmem_resp; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- pmem_read  in  1  line read request; held high by initiator until pmem_resp.
- pmem_write  in  1  line write request; held high by initiator until pmem_resp.
- pmem_address  in  16  byte address; bits [3:0] ignored; bits [LINES_LOG2+3:4] index the line.
- pmem_wdata  in  128  write line data; stable while pmem_write is high.
- pmem_resp  out  1  one-cycle completion pulse.
- pmem_rdata  out  128  read line data; valid in the pmem_resp cycle of a read.
- busy  out  1  high from acceptance through the pmem_resp cycle.
- protocol_error  out  1  sticky violation flag; cleared only by reset.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, counter=0, pmem_resp=0, pmem_rdata=0, busy=0, protocol_error=0.
  - Line-store contents are not reset.
  - An in-flight access is aborted; a pending write is never committed.
- IDLE:
  - If pmem_read or pmem_write is high, latch address line index, op and wdata; counter=LATENCY-1; go to WAIT (or RESP if LATENCY=1); busy=1 from the next cycle.
  - Both requests high at acceptance: treat as write, set protocol_error.
- WAIT:
  - Decrement counter each cycle; at counter=1, go to RESP.
  - Inputs are ignored except for abort detection.
  - If the latched request signal (pmem_read for a read, pmem_write for a write) falls during WAIT: set protocol_error, discard the access (no commit, no resp), return to IDLE.
- RESP (exactly one cycle):
  - pmem_resp=1, busy=1.
  - Read: pmem_rdata = line store[latched index], driven from a register loaded on the RESP entry edge.
  - Write: store[latched index] <= latched wdata at the clock edge ending RESP.
  - Next state IDLE.
- Latency: a request first sampled high at edge T produces pmem_resp high in the cycle after edge T+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
- Back-to-back requests:
  - The initiator may still hold the request high during the RESP cycle; this is not re-accepted there.
  - A request high in the cycle after RESP (IDLE) is a new access. This covers a writeback immediately followed by a miss read to a different line.
- pmem_rdata holds its value after RESP until the next read's RESP; writes do not change it.
- Read-after-write to the same line returns the newly written data, since the commit precedes any later read's RESP.
- Address wrap: index bits above LINES_LOG2+3 are ignored (aliasing).
- protocol_error is sticky and set by simultaneous requests or an early drop. It never blocks subsequent operation.

Test Plan:
- Reset, then write line 0x1230 with wdata=128'h00112233_44556677_8899AABB_CCDDEEFF (LATENCY=4) -> pmem_resp high exactly 4 cycles after acceptance for one cycle; busy high for those 4 cycles; protocol_error=0.
- Read 0x1238 after the previous write -> same line returned in the resp cycle: pmem_rdata=128'h00112233_44556677_8899AABB_CCDDEEFF; low address bits ignored.
- Write line 0x0040 (data A), resp, then a read of 0x0080 asserted the very next cycle -> two separate resp pulses 4 cycles apart from their acceptances; read returns prior content of 0x0080, line 0x0040 holds A.
- Assert pmem_read and pmem_write together at 0x0100 with data B -> treated as write, resp after 4 cycles, protocol_error=1 and stays 1; a later read of 0x0100 returns B.
- Write 0x0200 with data C, drop pmem_write after 2 cycles -> no pmem_resp, protocol_error=1, state IDLE; a later read of 0x0200 returns old content, not C.
- Start a write to 0x0300, pull reset_n low in the cycle before the expected resp -> pmem_resp never pulses, all outputs 0 next cycle, line 0x0300 unchanged; repeat with LATENCY=1 -> resp in the cycle immediately after acceptance.
